// File: rtl/uart_rx_parity.sv
// UART receiver: 8 data bits LSB first, odd parity, one stop bit.
// The frame completes at the stop-bit midpoint so that back-to-back frames are accepted.
module uart_rx_parity #(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       done_rx,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned Cpb    = clk_freq / baud_rate;
  localparam int unsigned TimerW = $clog2(Cpb);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(Cpb - 1);
  localparam logic [TimerW-1:0] HalfLast = TimerW'(Cpb / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rxs_q, rxs_prev_q;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_bad_q, par_bad_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                done_q, done_d;
  logic                fall;
  logic                tick;

  // Edge detection on the synchronized line; after a framing error rxs must return high first.
  assign fall = rxs_prev_q & ~rxs_q;

  always_comb begin
    tick = (state_q == StStart) ? (timer_q == HalfLast) : (timer_q == BitLast);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fall) state_d = StStart;
      StStart:  if (tick) state_d = rxs_q ? StIdle : StData;
      StData:   if (tick && (idx_q == 3'd7)) state_d = StParity;
      StParity: if (tick) state_d = StStop;
      StStop:   if (tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    timer_d      = timer_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    done_d       = 1'b0;

    if ((state_q == StIdle) || tick || (state_d != state_q)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    if (tick) begin
      case (state_q)
        StData: begin
          shift_d[idx_q] = rxs_q;
          idx_d          = idx_q + 3'd1;
        end
        StParity: par_bad_d = (rxs_q != ~^shift_q);
        StStop: begin
          rx_data_d    = shift_q;
          parity_err_d = par_bad_q;
          frame_err_d  = ~rxs_q;
          done_d       = 1'b1;
        end
        default: ;
      endcase
    end

    if (state_d != state_q) idx_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q      <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    rx_data    = rx_data_q;
    done_rx    = done_q;
    parity_err = parity_err_q;
    frame_err  = frame_err_q;
  end

endmodule

// File: doc/uart_rx_parity.md
UART_RX_PARITY -- requirements
Module: uart_rx_parity

Interface
REQ-001 SHALL have parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 9600, line bit rate in bit/s; CPB = clk_freq/baud_rate clocks per bit, integer division, CPB >= 8.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge; no derived clocks.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled externally.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data  output  8  last received data byte.
REQ-007 SHALL have port done_rx  output  1  one-clk pulse: frame complete; rx_data and error flags valid.
REQ-008 SHALL have port parity_err  output  1  parity check result of last frame; 1 = mismatch.
REQ-009 SHALL have port frame_err  output  1  stop-bit check result of last frame; 1 = stop sampled 0.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized signal rxs.
REQ-011 SHALL accept frame format: start 0, 8 data bits LSB first, 1 parity bit, 1 stop bit 1.
REQ-012 SHALL use odd parity: the expected parity bit is ~^data, i.e. data plus parity contain an odd number of ones.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, plus a clock-domain bit-timer (0..CPB-1) and a 3-bit data-bit index.
REQ-014 In IDLE: a falling edge on rxs (1 then 0) SHALL load the timer and enter START; otherwise remain in IDLE.
REQ-015 In START, at half-bit (CPB/2 clocks after the edge), rxs SHALL be sampled; if 1, return to IDLE (glitch rejected, no outputs change); if 0, enter DATA.
REQ-016 In DATA, rxs SHALL be sampled every CPB clocks after the start midpoint; bit i goes into a shift register position i; after bit index 7, enter PARITY.
REQ-017 In PARITY, one sample CPB clocks later SHALL be compared with ~^shift; the result is held internally.
REQ-018 In STOP, one sample CPB clocks later SHALL be taken; in the next clk, rx_data <= shift, parity_err and frame_err updated, done_rx = 1 for exactly one clk, state <= IDLE.
REQ-019 The frame SHALL complete at the stop-bit midpoint, not the stop-bit end, so a start edge immediately following the stop bit is detected (back-to-back frames).
REQ-020 rx_data, parity_err, frame_err SHALL hold their values until the next done_rx; a frame with errors still updates rx_data.
REQ-021 If stop is 0 (framing error), IDLE SHALL require rxs to return to 1 before a new falling edge is recognized; no frame is started while rxs stays 0.
REQ-022 Latency: done_rx SHALL assert 2 (sync) + CPB/2 + 10*CPB + 1 clk after the line start edge, +/-1 clk.
REQ-023 Timer and index SHALL not wrap out of range; all counters are sized for CPB and cleared on every state entry.

Reset
REQ-024 When rst = 0, SHALL immediately set state=IDLE, rx_data=8'h00, done_rx=0, parity_err=0, frame_err=0, synchronizer=1, timer=0, index=0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no done_rx; after release, reception restarts only on a fresh falling edge.

Verification (clk_freq=1000000, baud_rate=10000, CPB=100)
REQ-026 SHALL drive 0xA5, parity 1, stop 1 -> one done_rx pulse, rx_data=8'hA5, parity_err=0, frame_err=0.
REQ-027 SHALL drive 0xA5, parity 0 -> done_rx, rx_data=8'hA5, parity_err=1, frame_err=0.
REQ-028 SHALL drive 0x3C, parity 1, stop 0, line held low 300 clk then high -> done_rx, frame_err=1; no second done_rx until a new valid frame.
REQ-029 SHALL drive a rx low pulse of 20 clk -> no done_rx, outputs unchanged, next valid frame 0x01 (parity 0) received correctly.
REQ-030 SHALL drive back-to-back 0x00 (parity 1) then 0xFF (parity 1) with no idle gap -> two done_rx pulses, rx_data 8'h00 then 8'hFF, no errors.
REQ-031 SHALL assert rst=0 during data bit 4 of 0x55, then release -> outputs all 0, no done_rx; following 0x55 (parity 1) frame received with no errors.
